// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared constants and state encoding for the unified memory
//                port arbiter (MemRW decode values, arbiter FSM states).
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Decoded MemRW control from the data-memory stage
    localparam logic [1:0] MEMRW_NONE = 2'b00;
    localparam logic [1:0] MEMRW_WR   = 2'b01;
    localparam logic [1:0] MEMRW_RD   = 2'b10;
    localparam logic [1:0] MEMRW_ILL  = 2'b11;

    // Arbiter sequencing states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DM_BUSY = 3'd1,
        ST_IF_BUSY = 3'd2,
        ST_RESP    = 3'd3,
        ST_HALTED  = 3'd4
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Bundles the fetch, data-stage and memory-side signals of the
//                memory port arbiter. The arbiter uses the slave modport, the
//                surrounding pipeline/memory environment uses master.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // Instruction-fetch side
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;
    // Data-memory stage side
    logic [1:0]        dm_memrw;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_done;
    logic [DATA_W-1:0] dm_rdata;
    // Pipeline control
    logic              halt;
    logic              stall;
    logic              halted;
    logic              err;
    // Memory port
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;

    modport slave (
        input  if_req, if_addr, dm_memrw, dm_addr, dm_wdata, halt,
               mem_rdata, mem_done,
        output if_done, if_rdata, dm_done, dm_rdata, stall, halted, err,
               mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_memrw, dm_addr, dm_wdata, halt,
               mem_rdata, mem_done,
        input  if_done, if_rdata, dm_done, dm_rdata, stall, halted, err,
               mem_en, mem_wr, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_arb_perf_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_perf_ctr
//  Description : Saturating event counter; sticks at all-ones.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_perf_ctr #(
    parameter int W = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         inc,
    output logic      [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: increment on event unless already saturated
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one variable-latency memory port between instruction
//                fetch and the data-memory stage. One access in flight at a
//                time: request -> issue -> wait-for-done -> respond. Data wins
//                over fetch (older instruction). Handles HALT drain.
//                Optional macro MEM_ARB_PERF_EN adds saturating performance
//                counters (fetch dones, data dones, stall cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    mem_port_arbiter_if.slave   bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0]    perf_if_cnt,
    output logic [CNT_W-1:0]    perf_dm_cnt,
    output logic [CNT_W-1:0]    perf_stall_cnt
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    arb_state_e        state_q, state_d;
    logic              halt_pending_q, halt_pending_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              err_q, err_d;
    logic              dm_valid;

    // An illegal MemRW code is treated as no request
    assign dm_valid = (bus.dm_memrw == MEMRW_WR) || (bus.dm_memrw == MEMRW_RD);

    // Next-state and output computation for the sequencing FSM
    always_comb begin
        state_d        = state_q;
        halt_pending_d = halt_pending_q;
        mem_en_d       = 1'b0;
        mem_wr_d       = mem_wr_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        if_done_d      = 1'b0;
        dm_done_d      = 1'b0;
        if_rdata_d     = if_rdata_q;
        dm_rdata_d     = dm_rdata_q;
        err_d          = err_q | (bus.dm_memrw == MEMRW_ILL);

        // Remember a halt seen mid-access so the drain finishes first
        if (bus.halt && (state_q != ST_HALTED)) begin
            halt_pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (dm_valid) begin
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                    mem_wr_d    = bus.dm_memrw[0];
                    mem_en_d    = 1'b1;
                    state_d     = ST_DM_BUSY;
                end else if (bus.halt || halt_pending_q) begin
                    state_d = ST_HALTED;
                end else if (bus.if_req) begin
                    mem_addr_d = bus.if_addr;
                    mem_wr_d   = 1'b0;
                    mem_en_d   = 1'b1;
                    state_d    = ST_IF_BUSY;
                end
            end
            ST_DM_BUSY: begin
                if (bus.mem_done) begin
                    if (!mem_wr_q) begin
                        dm_rdata_d = bus.mem_rdata;
                    end
                    dm_done_d = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_IF_BUSY: begin
                if (bus.mem_done) begin
                    if_rdata_d = bus.mem_rdata;
                    if_done_d  = 1'b1;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                // Requests are not sampled here; the done pulse is visible now
                if (halt_pending_q || bus.halt) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            halt_pending_q <= 1'b0;
            mem_en_q       <= 1'b0;
            mem_wr_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            if_done_q      <= 1'b0;
            dm_done_q      <= 1'b0;
            if_rdata_q     <= '0;
            dm_rdata_q     <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            halt_pending_q <= halt_pending_d;
            mem_en_q       <= mem_en_d;
            mem_wr_q       <= mem_wr_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            if_done_q      <= if_done_d;
            dm_done_q      <= dm_done_d;
            if_rdata_q     <= if_rdata_d;
            dm_rdata_q     <= dm_rdata_d;
            err_q          <= err_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.dm_done   = dm_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.err       = err_q;
    assign bus.halted    = (state_q == ST_HALTED);
    assign bus.stall     = (bus.if_req && !if_done_q) ||
                           ((bus.dm_memrw != MEMRW_NONE) && !dm_done_q);

`ifdef MEM_ARB_PERF_EN
    logic perf_run;

    // Counters freeze once the core is halted
    assign perf_run = (state_q != ST_HALTED);

    mem_arb_perf_ctr #(.W(CNT_W)) u_perf_if (
        .clk (clk),
        .rst (rst),
        .inc (perf_run && if_done_q),
        .cnt (perf_if_cnt)
    );

    mem_arb_perf_ctr #(.W(CNT_W)) u_perf_dm (
        .clk (clk),
        .rst (rst),
        .inc (perf_run && dm_done_q),
        .cnt (perf_dm_cnt)
    );

    mem_arb_perf_ctr #(.W(CNT_W)) u_perf_stall (
        .clk (clk),
        .rst (rst),
        .inc (perf_run && bus.stall),
        .cnt (perf_stall_cnt)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed self-checking bench for mem_port_arbiter. Cycle k
//                is the interval after rising edge k; outputs are sampled
//                1 ns after the edge and inputs are changed at that point.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

`ifdef MEM_ARB_PERF_EN
    logic [3:0] perf_if_cnt;
    logic [3:0] perf_dm_cnt;
    logic [3:0] perf_stall_cnt;
`endif

    mem_port_arbiter #(
        .ADDR_W (16),
        .DATA_W (16),
        .CNT_W  (4)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_if_cnt    (perf_if_cnt),
        .perf_dm_cnt    (perf_dm_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory completes in the current cycle, then drops done
    task automatic mem_reply(input logic [15:0] data);
        bus.mem_done  = 1'b1;
        bus.mem_rdata = data;
        tick();
        bus.mem_done  = 1'b0;
        bus.mem_rdata = 16'h0000;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.if_req = 1'b0;   bus.if_addr = '0;
        bus.dm_memrw = 2'b00; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus.halt = 1'b0;     bus.mem_rdata = '0; bus.mem_done = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_wr", bus.mem_wr, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_if_done", bus.if_done, 0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_stall", bus.stall, 0);
        rst = 1'b0;
        tick();

        // T1: fetch with latency 2
        bus.if_req = 1'b1; bus.if_addr = 16'h0040;          // cycle 0
        tick();                                              // cycle 1
        chk("t1_en_c1", bus.mem_en, 1);
        chk("t1_addr_c1", bus.mem_addr, 16'h0040);
        chk("t1_wr_c1", bus.mem_wr, 0);
        chk("t1_stall_c1", bus.stall, 1);
        tick();                                              // cycle 2
        chk("t1_en_c2", bus.mem_en, 0);
        chk("t1_addr_c2", bus.mem_addr, 16'h0040);
        tick();                                              // cycle 3
        mem_reply(16'hA5C3);                                 // cycle 4
        chk("t1_if_done_c4", bus.if_done, 1);
        chk("t1_if_rdata_c4", bus.if_rdata, 16'hA5C3);
        chk("t1_en_c4", bus.mem_en, 0);
        chk("t1_stall_c4", bus.stall, 0);
        tick();                                              // cycle 5
        chk("t1_no_grant_c5", bus.mem_en, 0);
        chk("t1_if_done_c5", bus.if_done, 0);
        bus.if_req = 1'b0;
        tick();

        // T2: simultaneous fetch and load, data goes first
        bus.if_req = 1'b1; bus.if_addr = 16'h0300;
        bus.dm_memrw = 2'b10; bus.dm_addr = 16'h0100;
        tick();                                              // cycle 1
        chk("t2_en_c1", bus.mem_en, 1);
        chk("t2_addr_c1", bus.mem_addr, 16'h0100);
        chk("t2_wr_c1", bus.mem_wr, 0);
        tick();                                              // cycle 2
        mem_reply(16'hBEEF);                                 // cycle 3
        chk("t2_dm_done", bus.dm_done, 1);
        chk("t2_dm_rdata", bus.dm_rdata, 16'hBEEF);
        chk("t2_if_done", bus.if_done, 0);
        chk("t2_stall", bus.stall, 1);
        bus.dm_memrw = 2'b00;
        tick();                                              // cycle 4
        chk("t2_en_c4", bus.mem_en, 0);
        tick();                                              // cycle 5
        chk("t2_if_en", bus.mem_en, 1);
        chk("t2_if_addr", bus.mem_addr, 16'h0300);
        tick();                                              // cycle 6
        mem_reply(16'h1111);                                 // cycle 7
        chk("t2_if_done", bus.if_done, 1);
        chk("t2_if_rdata", bus.if_rdata, 16'h1111);
        bus.if_req = 1'b0;
        tick();

        // T3: store with latency 3, held bus, dm_rdata untouched
        bus.dm_memrw = 2'b01; bus.dm_addr = 16'h0200; bus.dm_wdata = 16'h1234;
        tick();                                              // cycle 1
        chk("t3_en_c1", bus.mem_en, 1);
        chk("t3_wr_c1", bus.mem_wr, 1);
        chk("t3_addr_c1", bus.mem_addr, 16'h0200);
        chk("t3_wdata_c1", bus.mem_wdata, 16'h1234);
        tick();                                              // cycle 2
        chk("t3_en_c2", bus.mem_en, 0);
        tick();                                              // cycle 3
        chk("t3_wr_c3", bus.mem_wr, 1);
        chk("t3_addr_c3", bus.mem_addr, 16'h0200);
        chk("t3_wdata_c3", bus.mem_wdata, 16'h1234);
        tick();                                              // cycle 4
        mem_reply(16'hFFFF);                                 // cycle 5
        chk("t3_dm_done", bus.dm_done, 1);
        chk("t3_dm_rdata_kept", bus.dm_rdata, 16'hBEEF);
        bus.dm_memrw = 2'b00;
        tick();
        chk("t3_dm_done_off", bus.dm_done, 0);

        // T4: halt during IF_BUSY drains the fetch, then HALTED
        bus.if_req = 1'b1; bus.if_addr = 16'h0050;
        tick();                                              // cycle 1
        chk("t4_en", bus.mem_en, 1);
        bus.halt = 1'b1;
        tick();                                              // cycle 2
        bus.halt = 1'b0;
        chk("t4_halted_c2", bus.halted, 0);
        mem_reply(16'h7777);                                 // cycle 3
        chk("t4_if_done", bus.if_done, 1);
        chk("t4_if_rdata", bus.if_rdata, 16'h7777);
        chk("t4_halted_c3", bus.halted, 0);
        tick();                                              // cycle 4
        chk("t4_halted_c4", bus.halted, 1);
        chk("t4_en_c4", bus.mem_en, 0);
        tick(); tick(); tick();
        chk("t4_ignored_req", bus.mem_en, 0);
        chk("t4_still_halted", bus.halted, 1);
        bus.if_req = 1'b0;

        // T5: illegal MemRW sets sticky err without a grant
        pulse_rst();
        bus.dm_memrw = 2'b11;
        tick();
        chk("t5_ill_no_en", bus.mem_en, 0);
        chk("t5_err_set", bus.err, 1);
        bus.dm_memrw = 2'b00;
        tick();
        chk("t5_err_held", bus.err, 1);

        // T6: halt together with a load in IDLE, load served first
        bus.dm_memrw = 2'b10; bus.dm_addr = 16'h0600; bus.halt = 1'b1;
        tick();                                              // cycle 1
        chk("t6_en", bus.mem_en, 1);
        chk("t6_addr", bus.mem_addr, 16'h0600);
        bus.halt = 1'b0;
        tick();                                              // cycle 2
        mem_reply(16'h2222);                                 // cycle 3
        chk("t6_dm_done", bus.dm_done, 1);
        chk("t6_dm_rdata", bus.dm_rdata, 16'h2222);
        chk("t6_halted_c3", bus.halted, 0);
        bus.dm_memrw = 2'b00;
        tick();                                              // cycle 4
        chk("t6_halted_c4", bus.halted, 1);
        chk("t6_err_still", bus.err, 1);

        // T7: asynchronous reset in the middle of DM_BUSY
        pulse_rst();
        bus.dm_memrw = 2'b01; bus.dm_addr = 16'h0400; bus.dm_wdata = 16'h0055;
        tick();                                              // cycle 1
        chk("t7_en", bus.mem_en, 1);
        tick();                                              // cycle 2, busy
        #2 rst = 1'b1;
        #1;
        chk("t7_rst_en", bus.mem_en, 0);
        chk("t7_rst_wr", bus.mem_wr, 0);
        chk("t7_rst_addr", bus.mem_addr, 0);
        chk("t7_rst_wdata", bus.mem_wdata, 0);
        chk("t7_rst_dm_rdata", bus.dm_rdata, 0);
        chk("t7_rst_if_rdata", bus.if_rdata, 0);
        chk("t7_rst_halted", bus.halted, 0);
        chk("t7_rst_err", bus.err, 0);
        bus.dm_memrw = 2'b00;
        tick();
        rst = 1'b0;
        tick();
        chk("t7_idle_no_en", bus.mem_en, 0);
        bus.if_req = 1'b1; bus.if_addr = 16'h0070;
        tick();
        chk("t7_fetch_after_rst", bus.mem_en, 1);
        chk("t7_fetch_addr", bus.mem_addr, 16'h0070);
        tick();
        mem_reply(16'h0A0A);
        chk("t7_fetch_done", bus.if_done, 1);
        bus.if_req = 1'b0;
        tick();

`ifdef MEM_ARB_PERF_EN
        // T8: 20 fetches saturate the 4-bit fetch counter at 15
        pulse_rst();
        for (int i = 0; i < 20; i++) begin
            bus.if_req = 1'b1; bus.if_addr = 16'(i);
            tick();
            tick();
            mem_reply(16'(i));
            bus.if_req = 1'b0;
            tick();
        end
        chk("t8_perf_if_sat", perf_if_cnt, 4'hF);
        chk("t8_perf_dm_zero", perf_dm_cnt, 4'h0);
        chk("t8_perf_stall_sat", perf_stall_cnt, 4'hF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified, variable-latency memory port between instruction fetch and the data-memory stage.
- The data side is driven by the decoded 2-bit MemRW control: 00 = none, 01 = write (ST/STU), 10 = read (LD).
- Sequences each access as request → issue → wait-for-done → respond, so at most one access is in flight.
- Holds the pipeline stalled and handles HALT drain.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
CNT_W, 16, width of optional performance counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
if_req  in  1  fetch request, level; held until if_done
if_addr  in  ADDR_W  fetch address (PC)
if_done  out  1  one-cycle pulse: fetch complete, if_rdata valid this cycle
if_rdata  out  DATA_W  fetched instruction, registered
dm_memrw  in  2  data request (00 none, 01 write, 10 read, 11 illegal); held until dm_done
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_done  out  1  one-cycle pulse: data access complete
dm_rdata  out  DATA_W  load data, registered; valid with dm_done on reads
halt  in  1  decoded Halt; level
mem_en  out  1  one-cycle issue strobe to memory
mem_wr  out  1  1 = write, 0 = read; stable while busy
mem_addr  out  ADDR_W  stable from issue until mem_done
mem_wdata  out  DATA_W  stable from issue until mem_done
mem_rdata  in  DATA_W  valid when mem_done = 1
mem_done  in  1  access-complete pulse; earliest 1 cycle after mem_en
stall  out  1  combinational: (if_req && !if_done) || (dm_memrw != 00 && !dm_done)
halted  out  1  high in HALTED state
err  out  1  sticky: illegal dm_memrw = 11 seen

Behaviour:
- Reset: all of the following are 0 and state = IDLE; any in-flight access is abandoned (memory must tolerate this):
  - mem_en, mem_wr, mem_addr, mem_wdata
  - if_done, dm_done, if_rdata, dm_rdata
  - halted, err
- States: IDLE, DM_BUSY, IF_BUSY, RESP, HALTED.
- IDLE, evaluated in priority order:
  - dm_memrw = 01/10: latch addr/wdata, set mem_wr = dm_memrw[0], pulse mem_en next cycle, go to DM_BUSY.
  - else halt (or halt_pending): go to HALTED.
  - else if_req: latch if_addr, mem_wr = 0, pulse mem_en, go to IF_BUSY.
  - else: stay.
  - Data beats fetch because the data access belongs to the older instruction.
- dm_memrw = 11: no grant; err set and held until rst. The request is treated as none.
- DM_BUSY / IF_BUSY:
  - mem_en low after its single cycle; mem_* held.
  - On mem_done: capture mem_rdata into dm_rdata/if_rdata (reads only), go to RESP.
  - mem_done while in IDLE/RESP/HALTED is ignored.
- RESP:
  - Pulse the matching done for exactly one cycle.
  - Requests are not sampled this cycle, so the requester can drop or replace its request.
  - Then go to IDLE.
- Latency:
  - Request high in cycle 0 → mem_en in cycle 1.
  - mem_done in cycle 1+L → done pulse in cycle 2+L.
  - Minimum 4 cycles request-to-next-grant when L = 1.
- halt while busy: set halt_pending; the current access completes normally, then HALTED after RESP.
- halt simultaneous with dm request in IDLE: data served first, then HALTED.
- HALTED: no grants; halted = 1; only rst exits.
- Write access: dm_rdata is not updated; dm_done still pulses.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- Defined: adds outputs perf_if_cnt, perf_dm_cnt, perf_stall_cnt (CNT_W each):
  - perf_if_cnt, perf_dm_cnt increment on each respective done pulse.
  - perf_stall_cnt increments every cycle stall = 1.
  - All saturate at all-ones, reset to 0, freeze in HALTED.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- mem_arb_pkg holds:
  - MEMRW_NONE = 2'b00, MEMRW_WR = 2'b01, MEMRW_RD = 2'b10, MEMRW_ILL = 2'b11.
  - State encodings ST_IDLE, ST_DM_BUSY, ST_IF_BUSY, ST_RESP, ST_HALTED.
- One natural sub-module: mem_arb_perf_ctr, a saturating counter instantiated three times under MEM_ARB_PERF_EN.

Test Plan:
- if_req = 1, if_addr = 0x0040, memory L = 2 returning 0xA5C3 → mem_en in cycle 1 with mem_addr = 0x0040, mem_wr = 0; if_done + if_rdata = 0xA5C3 in cycle 4; no grant in cycle 4.
- if_req and dm_memrw = 10 (addr 0x0100) both raised in the same cycle → data issued first; fetch issued only after the dm_done RESP cycle.
- dm_memrw = 01, addr 0x0200, wdata 0x1234 → mem_en/mem_wr = 1 with held addr/wdata until mem_done; dm_done pulses; dm_rdata unchanged.
- halt asserted during IF_BUSY → fetch completes, if_done pulses, halted = 1 next cycle; later if_req is ignored.
- dm_memrw = 11 → no mem_en, err = 1 and held; rst asserted mid-DM_BUSY → all outputs 0 immediately, err = 0, state IDLE.
- MEM_ARB_PERF_EN, CNT_W = 4: 20 fetches → perf_if_cnt saturates at 15.
